// File: rtl/lc3_mem_responder.sv
`timescale 1ns/1ps
// Unified LC3 instruction/data memory model with independent fetch and data ports.
// Latency 0 (combinational complete) or FETCH_LAT/DATA_LAT cycles; backdoor load stalls a coinciding write commit.

module lc3_port_fsm #(
  parameter int LAT = 0,
  parameter int KW  = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req,
  input  logic [KW-1:0] key,
  input  logic          stall,
  output logic          done,
  output logic          viol,
  output logic [KW-1:0] key_q
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] CNT_LD = (LAT > 0) ? 8'(LAT - 1) : 8'd0;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      key_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req) key_q <= key;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req && LAT > 0) begin
          cnt_nxt   = CNT_LD;
          state_nxt = (LAT == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        // a broken handshake abandons the access; IDLE re-samples next cycle
        if (viol) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 8'd1;
          if (cnt == 8'd1) state_nxt = DONE;
        end
      end
      DONE: begin
        if (!stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done = (state == DONE);
    viol = (state == WAIT) && (!req || key != key_q);
  end

endmodule

module lc3_mem_responder #(
  parameter int ADDR_W    = 16,
  parameter int FETCH_LAT = 0,
  parameter int DATA_LAT  = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        instrmem_rd,
  output logic [15:0] Instr_dout,
  output logic        complete_instr,
  input  logic        data_req,
  input  logic [15:0] Data_addr,
  input  logic        Data_rd,
  input  logic [15:0] Data_din,
  output logic [15:0] Data_dout,
  output logic        complete_data,
  input  logic        ld_en,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data,
  output logic        proto_err
);

  if (FETCH_LAT < 0 || FETCH_LAT > 255 || DATA_LAT < 0 || DATA_LAT > 255) begin : g_lat_check
    $error("lc3_mem_responder: latency parameters must be in 0..255");
  end

  logic [15:0] mem [0:(1 << ADDR_W) - 1];

  logic              f_done, f_viol, d_done, d_viol;
  logic [ADDR_W-1:0] f_key_q;
  logic [ADDR_W:0]   d_key_q;
  logic [ADDR_W-1:0] f_addr, d_addr;
  logic              d_rd, f_hit, d_hit, d_stall, wr_commit;
  logic [15:0]       instr_hold, data_hold;

  lc3_port_fsm #(.LAT(FETCH_LAT), .KW(ADDR_W)) u_fetch (
    .clock (clock),
    .reset (reset),
    .req   (instrmem_rd),
    .key   (pc[ADDR_W-1:0]),
    .stall (1'b0),
    .done  (f_done),
    .viol  (f_viol),
    .key_q (f_key_q)
  );

  lc3_port_fsm #(.LAT(DATA_LAT), .KW(ADDR_W + 1)) u_data (
    .clock (clock),
    .reset (reset),
    .req   (data_req),
    .key   ({Data_rd, Data_addr[ADDR_W-1:0]}),
    .stall (d_stall),
    .done  (d_done),
    .viol  (d_viol),
    .key_q (d_key_q)
  );

  assign f_addr = (FETCH_LAT == 0) ? pc[ADDR_W-1:0] : f_key_q;
  assign f_hit  = (FETCH_LAT == 0) ? instrmem_rd : f_done;
  assign d_addr = (DATA_LAT == 0) ? Data_addr[ADDR_W-1:0] : d_key_q[ADDR_W-1:0];
  assign d_rd   = (DATA_LAT == 0) ? Data_rd : d_key_q[ADDR_W];
  assign d_hit  = (DATA_LAT == 0) ? data_req : d_done;

  // backdoor owns the write port this cycle, so the DUT write waits one more
  assign d_stall   = d_hit && !d_rd && ld_en;
  assign complete_instr = f_hit && !reset;
  assign complete_data  = d_hit && !d_stall && !reset;
  assign wr_commit = complete_data && !d_rd;

  // reads see pre-edge contents, giving read-before-write on collisions
  assign Instr_dout = complete_instr ? mem[f_addr] : instr_hold;
  assign Data_dout  = (complete_data && d_rd) ? mem[d_addr] : data_hold;

  always_ff @(posedge clock) begin
    if (ld_en) begin
      mem[ld_addr[ADDR_W-1:0]] <= ld_data;
    end else if (wr_commit) begin
      mem[d_addr] <= Data_din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instr_hold <= '0;
      data_hold  <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (complete_instr) instr_hold <= Instr_dout;
      if (complete_data && d_rd) data_hold <= Data_dout;
      if (f_viol || d_viol) proto_err <= 1'b1;
    end
  end

endmodule
